data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data-memory controller for the RV32 datapath. It replaces the fixed word-only data memory and adds:
- byte, halfword and word loads and stores, with sign or zero extension on loads;
- a valid/ready request/response handshake with configurable wait states;
- detection of misaligned and out-of-range accesses.

It sits between the load/store unit and the data storage array.

## Interface
Parameters:
- DEPTH_WORDS, 128, number of 32-bit words stored
- ADDR_W, 9, byte-address width; requires 4*DEPTH_WORDS <= 2**ADDR_W
- WAIT_CYCLES, 0, extra cycles between request accept and response (0..15)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends (lbu/lhu); ignored for word and stores
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  access was misaligned, out-of-range or illegal size

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid && req_ready; request fields are latched on accept.
  - On accept, go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES), else go to RESP.
- WAIT:
  - Counter decrements each edge.
  - Go to RESP on the edge where the counter equals 1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err are held stable.
  - Return to IDLE on rsp_valid && rsp_ready.
  - req_ready=0, so there is no back-to-back overlap.
- Error, flagged at accept:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11;
  - addr >= 4*DEPTH_WORDS.
  - On error: no memory write, rsp_rdata=0, rsp_err=1.
- Stores:
  - Commit on the accept edge.
  - Byte writes lane addr[1:0] only.
  - Half writes lanes {addr[1],0} and {addr[1],1} only.
  - Word writes all lanes.
  - Unselected bytes are unchanged.
- Loads:
  - The word at addr[ADDR_W-1:2] is read on the edge entering RESP and registered.
  - The selected lane is shifted to bit 0, then sign- or zero-extended.
- Memory contents are not reset; reset affects control state only.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: accept at edge N → rsp_valid first high in the cycle after edge N+WAIT_CYCLES (WAIT_CYCLES=0 gives 1 cycle).
- rsp_valid stays high with stable data while rsp_ready=0.
- Throughput: one request per (WAIT_CYCLES+2) cycles when rsp_ready is tied high (accept, response, IDLE).
- Reset mid-operation:
  - A store already accepted stays committed.
  - A pending load is discarded and no response is issued.
- A load following a store to the same address returns the stored data; the store committed earlier.
- Address wrap-around does not occur; out-of-range addresses return an error and never alias.

## Structure
- Shared package data_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/WAIT/RESP;
  - function is_misaligned(size, addr[1:0]).
- Sub-module mem_lane_align (combinational) provides:
  - store byte-enable and data replication from size/addr[1:0];
  - load extraction and extension from word/size/addr[1:0]/unsigned.
- Storage array, FSM and wait counter live in data_mem_ctrl.

## Test plan
- sw 0xDEADBEEF @0x10, then lw @0x10 with WAIT_CYCLES=0 → rsp_valid one cycle after each accept; load returns 0xDEADBEEF, rsp_err=0.
- sb 0x80 @0x11 over 0xDEADBEEF → word becomes 0xDEAD80EF; lb @0x11 → 0xFFFFFF80; lbu @0x11 → 0x00000080.
- sh 0x8001 @0x12, then lh @0x12 → 0xFFFF8001; lhu → 0x00008001; lh @0x13 → rsp_err=1, rdata 0.
- sw @0x202 (misaligned) and sw @0x200 with DEPTH_WORDS=128 (range) → rsp_err=1; a following lw at the original word shows memory unchanged.
- WAIT_CYCLES=3 with rsp_ready held low 5 cycles → rsp_valid rises 3 cycles after accept and holds with stable data; req_ready stays 0 until the handshake completes.
- rst_n pulsed low during WAIT of a load → rsp_valid=0 and state IDLE immediately; the next lw returns correct data.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the RV32 data-memory controller.
package data_mem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

  // Natural-alignment check; the illegal size is reported separately.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = addr_lo[0];
    if (size == SZ_WORD) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replication and load extraction/extension.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the right-aligned data across lanes and enable only the addressed ones.
  always_comb begin
    st_be_o   = 4'b0000;
    st_data_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o   = 4'b0001 << st_addr_lo_i;
        st_data_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o   = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_wdata_i[15:0]}};
      end
      SZ_WORD: st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  // Load side: pull the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    ld_byte   = ld_word_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half   = ld_word_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o = '0;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      SZ_WORD: ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: valid/ready request/response, sized accesses, wait states,
// misalignment and range checking in front of a word-organised storage array.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned MemBytes = 4 * DEPTH_WORDS;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q, unsigned_q, err_q;
  logic [1:0]      size_q;
  logic [IdxW+1:0] addr_q;
  logic            req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]     rsp_rdata_q;

  logic            accept, req_err;
  logic            ld_we, ld_unsigned, ld_err;
  logic [1:0]      ld_size;
  logic [IdxW+1:0] ld_addr;
  logic [31:0]     ld_word, ld_data, rsp_data_d;
  logic [3:0]      st_be;
  logic [31:0]     st_data;

  // Accept decode, error classification and selection of the request feeding the response.
  // A zero-wait accept reads straight from the request; otherwise from the latched copy.
  always_comb begin
    accept  = req_valid && req_ready_q;
    req_err = (req_size == SZ_ILL) || is_misaligned(req_size, req_addr[1:0]) ||
              (32'(req_addr) >= MemBytes);
    if (state_q == StIdle) begin
      ld_we       = req_we;
      ld_size     = req_size;
      ld_unsigned = req_unsigned;
      ld_addr     = req_addr[IdxW+1:0];
      ld_err      = req_err;
    end else begin
      ld_we       = we_q;
      ld_size     = size_q;
      ld_unsigned = unsigned_q;
      ld_addr     = addr_q;
      ld_err      = err_q;
    end
    // Out-of-range indices never reach the array.
    ld_word    = ld_err ? '0 : mem_q[ld_addr[IdxW+1:2]];
    rsp_data_d = (ld_we || ld_err) ? '0 : ld_data;
  end

  mem_lane_align u_align (
    .st_size_i     (req_size),
    .st_addr_lo_i  (req_addr[1:0]),
    .st_wdata_i    (req_wdata),
    .st_be_o       (st_be),
    .st_data_o     (st_data),
    .ld_size_i     (ld_size),
    .ld_addr_lo_i  (ld_addr[1:0]),
    .ld_unsigned_i (ld_unsigned),
    .ld_word_i     (ld_word),
    .ld_data_o     (ld_data)
  );

  // Storage array: stores commit on the accept edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[req_addr[IdxW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Control FSM with wait counter, latched request and registered handshake/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            we_q        <= req_we;
            unsigned_q  <= req_unsigned;
            err_q       <= req_err;
            size_q      <= req_size;
            addr_q      <= req_addr[IdxW+1:0];
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_CYCLES);
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_data_d;
              rsp_err_q   <= req_err;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_data_d;
            rsp_err_q   <= err_q;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with no wait states, one with three.
// A byte-array memory model predicts every response.
module tb_data_mem_ctrl;

  localparam int unsigned AW = 10;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [AW-1:0] req_addr   [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [2][512];

  data_mem_ctrl #(.DEPTH_WORDS(128), .ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(128), .ADDR_W(AW), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory of 512 bytes, natural alignment required.
  task automatic model(input int d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int n;
    int a;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a   = int'(addr);
    err = (sz == 2'd3) || (a % n != 0) || (a >= 512);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[d][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_m[d][a+i];
        if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8*n)) - 32'h1);
      end
    end
  endtask

  // Present one request for exactly one accepting edge.
  task automatic issue(input int d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk({31'h0, req_ready[d]}, 32'h1, "ready_idle");
    req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  // Full transaction: latency, response contents, hold stability and handshake release.
  task automatic txn(input int d, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [AW-1:0] addr, input logic [31:0] wd, input int hold,
                     input string tag, output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    model(d, we, sz, uns, addr, wd, exp_d, exp_e);
    rsp_ready[d] = 1'b0;
    issue(d, we, sz, uns, addr, wd);
    lat = 0;
    @(negedge clk);
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk(lat, (d == 0) ? 0 : 3, {tag, "/latency"});
    chk({31'h0, req_ready[d]}, 32'h0, {tag, "/ready_busy"});
    got_d = rsp_rdata[d];
    got_e = rsp_err[d];
    chk(got_d, exp_d, {tag, "/rdata"});
    chk({31'h0, got_e}, {31'h0, exp_e}, {tag, "/err"});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({31'h0, rsp_valid[d]}, 32'h1, {tag, "/hold_valid"});
      chk(rsp_rdata[d], exp_d, {tag, "/hold_rdata"});
      chk({31'h0, req_ready[d]}, 32'h0, {tag, "/hold_ready"});
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk({31'h0, rsp_valid[d]}, 32'h0, {tag, "/valid_drop"});
    chk({31'h0, req_ready[d]}, 32'h1, {tag, "/ready_back"});
  endtask

  initial begin
    logic [31:0] gd, ed;
    logic        ge, ee;
    int          d;
    logic [1:0]  sz;
    logic [AW-1:0] ad;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'd0; req_unsigned[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({31'h0, req_ready[k]}, 32'h1, "rst_ready");
      chk({31'h0, rsp_valid[k]}, 32'h0, "rst_valid");
      chk(rsp_rdata[k], 32'h0, "rst_rdata");
      chk({31'h0, rsp_err[k]}, 32'h0, "rst_err");
    end
    rst_n = 1'b1;

    // Give every word a known value so any later load is predictable.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 128; w++) txn(k, 1'b1, 2'd2, 1'b0, AW'(w*4), $urandom, 0, "fill", gd, ge);
    end

    // Directed sequence on the zero-wait instance.
    txn(0, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0, "sw10", gd, ge);
    chk(gd, 32'h0, "sw10_rdata0");
    txn(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, "lw10", gd, ge);
    chk(gd, 32'hDEADBEEF, "lw10_const");
    txn(0, 1'b1, 2'd0, 1'b0, 10'h011, 32'h80, 0, "sb11", gd, ge);
    txn(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, "lw10b", gd, ge);
    chk(gd, 32'hDEAD80EF, "sb_merge_const");
    txn(0, 1'b0, 2'd0, 1'b0, 10'h011, 32'h0, 0, "lb11", gd, ge);
    chk(gd, 32'hFFFFFF80, "lb11_const");
    txn(0, 1'b0, 2'd0, 1'b1, 10'h011, 32'h0, 0, "lbu11", gd, ge);
    chk(gd, 32'h00000080, "lbu11_const");
    txn(0, 1'b1, 2'd1, 1'b0, 10'h012, 32'h8001, 0, "sh12", gd, ge);
    txn(0, 1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 0, "lh12", gd, ge);
    chk(gd, 32'hFFFF8001, "lh12_const");
    txn(0, 1'b0, 2'd1, 1'b1, 10'h012, 32'h0, 0, "lhu12", gd, ge);
    chk(gd, 32'h00008001, "lhu12_const");
    txn(0, 1'b0, 2'd1, 1'b0, 10'h013, 32'h0, 0, "lh13", gd, ge);
    chk({31'h0, ge}, 32'h1, "lh13_err_const");
    txn(0, 1'b1, 2'd2, 1'b0, 10'h202, 32'h12345678, 0, "sw202", gd, ge);
    chk({31'h0, ge}, 32'h1, "sw202_err_const");
    txn(0, 1'b1, 2'd2, 1'b0, 10'h200, 32'h12345678, 0, "sw200", gd, ge);
    chk({31'h0, ge}, 32'h1, "sw200_err_const");
    txn(0, 1'b1, 2'd3, 1'b0, 10'h010, 32'h12345678, 0, "sz11", gd, ge);
    chk({31'h0, ge}, 32'h1, "sz11_err_const");
    txn(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, "lw10c", gd, ge);
    chk(gd, 32'h800180EF, "unchanged_const");

    // Wait-state instance with a stalled consumer.
    txn(1, 1'b1, 2'd2, 1'b0, 10'h020, 32'hA5A55A5A, 5, "w3_sw", gd, ge);
    txn(1, 1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 5, "w3_lw", gd, ge);
    chk(gd, 32'hA5A55A5A, "w3_lw_const");

    // Reset during WAIT: accepted store stays, pending load vanishes.
    model(1, 1'b1, 2'd2, 1'b0, 10'h040, 32'hCAFEF00D, ed, ee);
    issue(1, 1'b1, 2'd2, 1'b0, 10'h040, 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({31'h0, rsp_valid[1]}, 32'h0, "rst_st_valid");
    chk({31'h0, req_ready[1]}, 32'h1, "rst_st_ready");
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1'b0, 2'd2, 1'b0, 10'h044, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({31'h0, rsp_valid[1]}, 32'h0, "rst_ld_valid");
    chk({31'h0, req_ready[1]}, 32'h1, "rst_ld_ready");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk({31'h0, rsp_valid[1]}, 32'h0, "rst_no_rsp");
    end
    txn(1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 0, "post_rst_lw", gd, ge);
    chk(gd, 32'hCAFEF00D, "post_rst_const");

    // Randomised mix on both instances.
    for (int n = 0; n < 120; n++) begin
      d  = n % 2;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(512, 1023))
                                       : AW'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) ad = ad & ~AW'((sz == 2'd2) ? 3 : sz);
      txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
          $urandom_range(0, 3), "rand", gd, ge);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
